// File: rtl/gemm_addr_gen.sv
// GeMM address generator: maps controller M/K/N block indices to SRAM block
// addresses for A/B reads (one-cycle registered) and queues the C address of each
// output block whose final K step was issued, for a valid/ready writeback port.
module gemm_addr_gen #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned PendDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 done_i,
  input  logic [AddrWidth-1:0] a_base_i,
  input  logic [AddrWidth-1:0] b_base_i,
  input  logic [AddrWidth-1:0] c_base_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] K_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0] M_count_i,
  input  logic [AddrWidth-1:0] K_count_i,
  input  logic [AddrWidth-1:0] N_count_i,
  input  logic                 rd_en_i,
  output logic [AddrWidth-1:0] a_addr_o,
  output logic [AddrWidth-1:0] b_addr_o,
  output logic                 rd_valid_o,
  output logic [AddrWidth-1:0] c_addr_o,
  output logic                 c_wvalid_o,
  input  logic                 c_wready_i,
  output logic                 busy_o,
  output logic                 cfg_err_o,
  output logic                 overflow_o
);

  localparam int unsigned PtrW = $clog2(PendDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   a_base_q, a_base_d;
  logic [AddrWidth-1:0]   b_base_q, b_base_d;
  logic [AddrWidth-1:0]   c_base_q, c_base_d;
  logic [AddrWidth-1:0]   k_size_q, k_size_d;
  logic [AddrWidth-1:0]   n_size_q, n_size_d;
  logic [AddrWidth-1:0]   a_addr_q, a_addr_d;
  logic [AddrWidth-1:0]   b_addr_q, b_addr_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   overflow_q, overflow_d;
  logic [PtrW-1:0]        head_q, head_d;
  logic [PtrW-1:0]        tail_q, tail_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [AddrWidth-1:0]   mem_q [PendDepth];
  logic [AddrWidth-1:0]   mem_d [PendDepth];

  logic                   start_ok;
  logic                   rd_fire;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   push_ok;
  logic [AddrWidth-1:0]   a_calc;
  logic [AddrWidth-1:0]   b_calc;
  logic [AddrWidth-1:0]   c_calc;

  // Address arithmetic from latched configuration; products wrap at AddrWidth.
  always_comb begin
    a_calc = a_base_q + M_count_i * k_size_q + K_count_i;
    b_calc = b_base_q + K_count_i * n_size_q + N_count_i;
    c_calc = c_base_q + M_count_i * n_size_q + N_count_i;
  end

  // Next-state, read path and C-queue bookkeeping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    c_base_d   = c_base_q;
    k_size_d   = k_size_q;
    n_size_d   = n_size_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    overflow_d = overflow_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_d      = mem_q;

    // M size only bounds the controller's loop; it matters here just for the zero check.
    start_ok  = start_i && (M_size_i != '0) && (K_size_i != '0) && (N_size_i != '0);
    cfg_err_d = start_i && !start_ok;

    rd_fire    = rd_en_i && (state_q == StRun);
    rd_valid_d = rd_fire;
    if (rd_fire) begin
      a_addr_d = a_calc;
      b_addr_d = b_calc;
    end

    full    = (count_q == CntW'(PendDepth));
    push    = rd_fire && (K_count_i == k_size_q - AddrWidth'(1));
    pop     = (count_q != '0) && c_wready_i;
    push_ok = push && (!full || pop);

    if (start_ok) begin
      // Restart: flush the queue and relatch, regardless of the current state.
      state_d    = StRun;
      a_base_d   = a_base_i;
      b_base_d   = b_base_i;
      c_base_d   = c_base_i;
      k_size_d   = K_size_i;
      n_size_d   = N_size_i;
      overflow_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push && full && !pop) begin
        overflow_d = 1'b1;
      end
      if (push_ok) begin
        mem_d[tail_q] = c_calc;
        tail_d        = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      if (push_ok && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push_ok) begin
        count_d = count_q - CntW'(1);
      end

      unique case (state_q)
        StRun:   if (done_i) state_d = StDrain;
        StDrain: if ((count_q == '0) && !push_ok) state_d = StIdle;
        default: state_d = state_q;
      endcase
    end
  end

  // State, configuration, read-path and queue registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      k_size_q   <= '0;
      n_size_q   <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      rd_valid_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      // NOTE: the queue storage is only a few words and is reset so c_addr_o reads 0 after reset.
      for (int i = 0; i < int'(PendDepth); i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      c_base_q   <= c_base_d;
      k_size_q   <= k_size_d;
      n_size_q   <= n_size_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      rd_valid_q <= rd_valid_d;
      cfg_err_q  <= cfg_err_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign a_addr_o   = a_addr_q;
  assign b_addr_o   = b_addr_q;
  assign rd_valid_o = rd_valid_q;
  assign c_addr_o   = mem_q[head_q];
  assign c_wvalid_o = (count_q != '0);
  assign busy_o     = (state_q != StIdle);
  assign cfg_err_o  = cfg_err_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_gemm_addr_gen.sv
// Directed self-checking bench for gemm_addr_gen with hand-computed expectations.
module tb_gemm_addr_gen;

  localparam int unsigned AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          done_i = 1'b0;
  logic [AW-1:0] a_base_i = '0, b_base_i = '0, c_base_i = '0;
  logic [AW-1:0] M_size_i = '0, K_size_i = '0, N_size_i = '0;
  logic [AW-1:0] M_count_i = '0, K_count_i = '0, N_count_i = '0;
  logic          rd_en_i = 1'b0;
  logic [AW-1:0] a_addr_o, b_addr_o, c_addr_o;
  logic          rd_valid_o, c_wvalid_o, c_wready_i = 1'b0;
  logic          busy_o, cfg_err_o, overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  gemm_addr_gen #(.AddrWidth(AW), .PendDepth(4)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .done_i     (done_i),
    .a_base_i   (a_base_i),
    .b_base_i   (b_base_i),
    .c_base_i   (c_base_i),
    .M_size_i   (M_size_i),
    .K_size_i   (K_size_i),
    .N_size_i   (N_size_i),
    .M_count_i  (M_count_i),
    .K_count_i  (K_count_i),
    .N_count_i  (N_count_i),
    .rd_en_i    (rd_en_i),
    .a_addr_o   (a_addr_o),
    .b_addr_o   (b_addr_o),
    .rd_valid_o (rd_valid_o),
    .c_addr_o   (c_addr_o),
    .c_wvalid_o (c_wvalid_o),
    .c_wready_i (c_wready_i),
    .busy_o     (busy_o),
    .cfg_err_o  (cfg_err_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c,
                       input logic [AW-1:0] m, input logic [AW-1:0] k, input logic [AW-1:0] n);
    a_base_i = a; b_base_i = b; c_base_i = c;
    M_size_i = m; K_size_i = k; N_size_i = n;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // One controller advance with the given indices.
  task automatic rd(input logic [AW-1:0] m, input logic [AW-1:0] k, input logic [AW-1:0] n);
    M_count_i = m; K_count_i = k; N_count_i = n;
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] held_a;

    // Reset state.
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_wvalid", c_wvalid_o, 0);
    check("rst_c_addr", c_addr_o, 0);
    check("rst_a_addr", a_addr_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // Basic run: M=K=N=2, k innermost; C completes on every k=1 step.
    start(16'h0100, 16'h0200, 16'h0300, 2, 2, 2);
    check("run_busy", busy_o, 1);
    for (int m = 0; m < 2; m++)
      for (int n = 0; n < 2; n++)
        for (int k = 0; k < 2; k++) begin
          rd(AW'(m), AW'(k), AW'(n));
          check("seq_a", a_addr_o, 32'h100 + 32'(m * 2 + k));
          check("seq_b", b_addr_o, 32'h200 + 32'(k * 2 + n));
          check("seq_rdv", rd_valid_o, 1);
        end
    held_a = 16'h0103;
    step();
    check("idle_rdv", rd_valid_o, 0);
    check("hold_a", a_addr_o, held_a);
    check("full_no_ovf", overflow_o, 0);
    c_wready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pop_valid", c_wvalid_o, 1);
      check("pop_addr", c_addr_o, 32'h300 + 32'(i));
      step();
    end
    check("pop_empty", c_wvalid_o, 0);

    // Overflow: five completions into a four-entry queue with no consumer.
    c_wready_i = 1'b0;
    rd(0, 1, 0); rd(0, 1, 1); rd(1, 1, 0); rd(1, 1, 1);
    check("four_no_ovf", overflow_o, 0);
    rd(0, 1, 0);
    check("ovf_set", overflow_o, 1);
    check("ovf_head", c_addr_o, 16'h0300);
    check("ovf_valid", c_wvalid_o, 1);

    // Mid-run restart flushes the queue and clears overflow.
    start(16'h0100, 16'h0200, 16'h0300, 2, 2, 2);
    check("restart_ovf", overflow_o, 0);
    check("restart_flush", c_wvalid_o, 0);
    check("restart_busy", busy_o, 1);

    // Full queue with simultaneous push and pop.
    rd(0, 1, 0); rd(0, 1, 1); rd(1, 1, 0); rd(1, 1, 1);
    c_wready_i = 1'b1;
    rd(1, 1, 0);
    c_wready_i = 1'b0;
    check("pp_no_ovf", overflow_o, 0);
    exp_q = '{16'h0301, 16'h0302, 16'h0303, 16'h0302};
    c_wready_i = 1'b1;
    foreach (exp_q[i]) begin
      check("pp_valid", c_wvalid_o, 1);
      check("pp_addr", c_addr_o, exp_q[i]);
      step();
    end
    check("pp_empty", c_wvalid_o, 0);
    c_wready_i = 1'b0;

    // Zero-size start is rejected without relatch or flush.
    rd(0, 1, 0);
    start(16'h0500, 16'h0600, 16'h0700, 2, 0, 2);
    check("cfg_err_pulse", cfg_err_o, 1);
    check("cfg_busy", busy_o, 1);
    check("cfg_no_flush", c_wvalid_o, 1);
    rd(0, 1, 1);
    check("cfg_err_clear", cfg_err_o, 0);
    check("cfg_no_relatch_a", a_addr_o, 16'h0101);
    check("cfg_no_relatch_b", b_addr_o, 16'h0203);

    // Asynchronous reset mid-run with three entries queued.
    rd(1, 1, 0);
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_wvalid", c_wvalid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_c_addr", c_addr_o, 0);
    check("arst_a_addr", a_addr_o, 0);
    check("arst_b_addr", b_addr_o, 0);
    check("arst_rdv", rd_valid_o, 0);
    check("arst_ovf", overflow_o, 0);
    step();
    check("arst_edge_wvalid", c_wvalid_o, 0);
    rst_ni = 1'b1;
    step();

    // C address wrap, then done -> DRAIN -> IDLE once the queue empties.
    start(16'h0000, 16'h0000, 16'hFFFF, 1, 1, 2);
    rd(0, 0, 0);
    check("wrap_b0", b_addr_o, 0);
    rd(0, 0, 1);
    check("wrap_b1", b_addr_o, 1);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    check("drain_busy", busy_o, 1);
    rd(0, 0, 0);
    check("drain_rd_ignored", rd_valid_o, 0);
    c_wready_i = 1'b1;
    check("wrap_c0", c_addr_o, 16'hFFFF);
    step();
    check("wrap_c1", c_addr_o, 16'h0000);
    check("wrap_c1_valid", c_wvalid_o, 1);
    step();
    check("drain_empty", c_wvalid_o, 0);
    check("drain_still_busy", busy_o, 1);
    step();
    check("drain_idle", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
